// File: rtl/rpn_evaluator_if.sv
`default_nettype none
// ============================================================================
// Module      : rpn_evaluator_if
// Description : Start/result handshake and token-read port bundle for the
//               RPN expression evaluator.
// Revision    : 1.0 - initial release
// ============================================================================
interface rpn_evaluator_if #(
    parameter int NUMBER_WIDTH = 16,
    parameter int INDEX_WIDTH  = 6
);
    logic                    start;
    logic                    ready;
    logic [NUMBER_WIDTH-1:0] x;
    logic [INDEX_WIDTH-1:0]  token_count;
    logic                    token_rd_en;
    logic [INDEX_WIDTH-1:0]  token_index;
    logic [NUMBER_WIDTH:0]   token_data;
    logic                    token_valid;
    logic [NUMBER_WIDTH-1:0] result;
    logic                    result_valid;
    logic                    error;

    modport master (
        output start, x, token_count, token_data, token_valid,
        input  ready, token_rd_en, token_index, result, result_valid, error
    );

    modport slave (
        input  start, x, token_count, token_data, token_valid,
        output ready, token_rd_en, token_index, result, result_valid, error
    );
endinterface
`default_nettype wire

// File: rtl/rpn_evaluator.sv
`default_nettype none
// ============================================================================
// Module      : rpn_evaluator
// Description : Fixed-point reverse-polish evaluator with a value stack,
//               iterative divider and repeated-multiply power unit.
// Revision    : 1.0 - initial release
// ============================================================================
module rpn_evaluator #(
    parameter int INTEGER_PART_WIDTH    = 8,
    parameter int FRACTIONAL_PART_WIDTH = 8,
    parameter int TOKEN_QUEUE_SIZE      = 64,
    parameter int STACK_SIZE            = 16
) (
    input  wire logic      clk,
    input  wire logic      rst,
    rpn_evaluator_if.slave bus
);
    localparam int NUMBER_WIDTH  = INTEGER_PART_WIDTH + FRACTIONAL_PART_WIDTH;
    localparam int INDEX_WIDTH   = $clog2(TOKEN_QUEUE_SIZE);
    localparam int SP_WIDTH      = $clog2(STACK_SIZE);
    localparam int DEPTH_WIDTH   = $clog2(STACK_SIZE + 1);
    localparam int DIV_WIDTH     = NUMBER_WIDTH + FRACTIONAL_PART_WIDTH;
    localparam int DIV_CNT_WIDTH = $clog2(DIV_WIDTH + 1);

    localparam logic [2:0] c_op_plus = 3'd0;
    localparam logic [2:0] c_op_sub  = 3'd1;
    localparam logic [2:0] c_op_mul  = 3'd2;
    localparam logic [2:0] c_op_div  = 3'd3;
    localparam logic [2:0] c_op_pow  = 3'd4;
    localparam logic [2:0] c_op_var  = 3'd6;
    localparam logic [NUMBER_WIDTH-1:0] c_fixed_one = NUMBER_WIDTH'(1) << FRACTIONAL_PART_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_FETCH      = 3'd1,
        S_WAIT_TOKEN = 3'd2,
        S_EXEC       = 3'd3,
        S_DIVIDE     = 3'd4,
        S_POWER      = 3'd5,
        S_DONE       = 3'd6
    } state_t;

    state_t r_state, w_next_state;

    logic        [NUMBER_WIDTH-1:0]       r_x;
    logic        [INDEX_WIDTH-1:0]        r_token_count;
    logic        [INDEX_WIDTH-1:0]        r_index;
    logic        [NUMBER_WIDTH:0]         r_token;
    logic        [DEPTH_WIDTH-1:0]        r_depth;
    logic signed [NUMBER_WIDTH-1:0]       r_stack [STACK_SIZE];
    logic        [NUMBER_WIDTH-1:0]       r_result;
    logic                                 r_result_valid;
    logic                                 r_error;
    logic        [DIV_WIDTH-1:0]          r_div_quot;
    logic        [NUMBER_WIDTH-1:0]       r_div_rem;
    logic        [NUMBER_WIDTH-1:0]       r_divisor;
    logic                                 r_div_neg;
    logic        [DIV_CNT_WIDTH-1:0]      r_div_cnt;
    logic        [NUMBER_WIDTH-1:0]       r_pow_acc;
    logic        [NUMBER_WIDTH-1:0]       r_pow_base;
    logic        [INTEGER_PART_WIDTH-1:0] r_pow_cnt;

    logic                           w_ready, w_rd_en, w_op_done, w_exec_error, w_last;
    logic                           w_is_op, w_has_two, w_full, w_push, w_rem_ge;
    logic        [2:0]              w_opcode;
    logic signed [NUMBER_WIDTH-1:0] w_top, w_second;
    logic        [NUMBER_WIDTH-1:0] w_abs_a, w_abs_b, w_alu, w_push_val, w_div_result;
    logic        [NUMBER_WIDTH:0]   w_rem_shift;
    logic        [NUMBER_WIDTH-1:0] w_rem_next;
    logic        [DIV_WIDTH-1:0]    w_quot_next, w_quot_signed;

    // Q-format multiply: full signed product, drop the extra fraction bits, keep the low word.
    function automatic logic [NUMBER_WIDTH-1:0] fx_mul(input logic signed [NUMBER_WIDTH-1:0] a,
                                                       input logic signed [NUMBER_WIDTH-1:0] b);
        logic signed [2*NUMBER_WIDTH-1:0] p;
        p = a * b;
        return p[FRACTIONAL_PART_WIDTH +: NUMBER_WIDTH];
    endfunction

    assign w_is_op    = r_token[NUMBER_WIDTH];
    assign w_opcode   = r_token[2:0];
    assign w_top      = r_stack[SP_WIDTH'(r_depth - DEPTH_WIDTH'(1))];
    assign w_second   = r_stack[SP_WIDTH'(r_depth - DEPTH_WIDTH'(2))];
    assign w_has_two  = r_depth >= DEPTH_WIDTH'(2);
    assign w_full     = r_depth == DEPTH_WIDTH'(STACK_SIZE);
    assign w_last     = (r_index + INDEX_WIDTH'(1)) == r_token_count;
    assign w_push     = !w_is_op || (w_opcode == c_op_var);
    assign w_push_val = w_is_op ? r_x : r_token[NUMBER_WIDTH-1:0];
    assign w_abs_a    = w_second[NUMBER_WIDTH-1] ? -w_second : w_second;
    assign w_abs_b    = w_top[NUMBER_WIDTH-1] ? -w_top : w_top;

    always_comb begin
        w_alu = '0;
        case (w_opcode)
            c_op_plus: w_alu = w_second + w_top;
            c_op_sub:  w_alu = w_second - w_top;
            c_op_mul:  w_alu = fx_mul(w_second, w_top);
            default:   w_alu = '0;
        endcase
    end

    // One restoring-division step; the dividend register shifts the quotient in from the right.
    assign w_rem_shift   = {r_div_rem, r_div_quot[DIV_WIDTH-1]};
    assign w_rem_ge      = w_rem_shift >= {1'b0, r_divisor};
    assign w_rem_next    = w_rem_ge ? NUMBER_WIDTH'(w_rem_shift - {1'b0, r_divisor})
                                    : w_rem_shift[NUMBER_WIDTH-1:0];
    assign w_quot_next   = {r_div_quot[DIV_WIDTH-2:0], w_rem_ge};
    assign w_quot_signed = r_div_neg ? -w_quot_next : w_quot_next;
    assign w_div_result  = w_quot_signed[NUMBER_WIDTH-1:0];

    always_comb begin
        w_exec_error = 1'b0;
        if (!w_is_op) begin
            w_exec_error = w_full;
        end else begin
            case (w_opcode)
                c_op_plus, c_op_sub, c_op_mul: w_exec_error = !w_has_two;
                c_op_div: w_exec_error = !w_has_two || (w_top == '0);
                c_op_pow: w_exec_error = !w_has_two || w_top[NUMBER_WIDTH-1];
                c_op_var: w_exec_error = w_full;
                default:  w_exec_error = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_op_done    = 1'b0;
        w_ready      = (r_state == S_IDLE);
        w_rd_en      = (r_state == S_FETCH);
        case (r_state)
            S_IDLE:       if (bus.start) w_next_state = (bus.token_count == '0) ? S_DONE : S_FETCH;
            S_FETCH:      w_next_state = S_WAIT_TOKEN;
            S_WAIT_TOKEN: if (bus.token_valid) w_next_state = S_EXEC;
            S_EXEC: begin
                if (w_exec_error)                             w_next_state = S_DONE;
                else if (w_is_op && (w_opcode == c_op_div))   w_next_state = S_DIVIDE;
                else if (w_is_op && (w_opcode == c_op_pow))   w_next_state = S_POWER;
                else                                          w_op_done    = 1'b1;
            end
            S_DIVIDE:     if (r_div_cnt == DIV_CNT_WIDTH'(1)) w_op_done = 1'b1;
            S_POWER:      if (r_pow_cnt == '0) w_op_done = 1'b1;
            S_DONE:       w_next_state = S_IDLE;
            default:      w_next_state = S_IDLE;
        endcase
        if (w_op_done) w_next_state = w_last ? S_DONE : S_FETCH;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x            <= '0;
            r_token_count  <= '0;
            r_index        <= '0;
            r_token        <= '0;
            r_depth        <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_error        <= 1'b0;
            r_div_quot     <= '0;
            r_div_rem      <= '0;
            r_divisor      <= '0;
            r_div_neg      <= 1'b0;
            r_div_cnt      <= '0;
            r_pow_acc      <= '0;
            r_pow_base     <= '0;
            r_pow_cnt      <= '0;
        end else begin
            r_result_valid <= 1'b0;
            case (r_state)
                S_IDLE: if (bus.start) begin
                    r_x           <= bus.x;
                    r_token_count <= bus.token_count;
                    r_index       <= '0;
                    r_depth       <= '0;
                    r_result      <= '0;
                    r_error       <= (bus.token_count == '0);
                end
                S_WAIT_TOKEN: if (bus.token_valid) r_token <= bus.token_data;
                S_EXEC: begin
                    if (w_exec_error) begin
                        r_error <= 1'b1;
                    end else if (w_push) begin
                        r_depth <= r_depth + DEPTH_WIDTH'(1);
                    end else if (w_opcode == c_op_div) begin
                        r_div_quot <= {w_abs_a, FRACTIONAL_PART_WIDTH'(0)};
                        r_div_rem  <= '0;
                        r_divisor  <= w_abs_b;
                        r_div_neg  <= w_second[NUMBER_WIDTH-1] ^ w_top[NUMBER_WIDTH-1];
                        r_div_cnt  <= DIV_CNT_WIDTH'(DIV_WIDTH);
                    end else if (w_opcode == c_op_pow) begin
                        r_pow_acc  <= c_fixed_one;
                        r_pow_base <= w_second;
                        r_pow_cnt  <= w_top[NUMBER_WIDTH-1:FRACTIONAL_PART_WIDTH];
                    end else begin
                        r_depth <= r_depth - DEPTH_WIDTH'(1);
                    end
                end
                S_DIVIDE: begin
                    r_div_quot <= w_quot_next;
                    r_div_rem  <= w_rem_next;
                    r_div_cnt  <= r_div_cnt - DIV_CNT_WIDTH'(1);
                    if (w_op_done) r_depth <= r_depth - DEPTH_WIDTH'(1);
                end
                S_POWER: begin
                    if (w_op_done) begin
                        r_depth <= r_depth - DEPTH_WIDTH'(1);
                    end else begin
                        r_pow_acc <= fx_mul(r_pow_acc, r_pow_base);
                        r_pow_cnt <= r_pow_cnt - INTEGER_PART_WIDTH'(1);
                    end
                end
                S_DONE: begin
                    r_result_valid <= 1'b1;
                    if (!r_error) begin
                        if (r_depth == DEPTH_WIDTH'(1)) r_result <= w_top;
                        else                            r_error  <= 1'b1;
                    end
                end
                default: ;
            endcase
            if (w_op_done) r_index <= r_index + INDEX_WIDTH'(1);
        end
    end

    // Stack storage carries no reset; depth alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (r_state == S_EXEC && !w_exec_error) begin
            if (w_push)
                r_stack[SP_WIDTH'(r_depth)] <= w_push_val;
            else if (w_opcode != c_op_div && w_opcode != c_op_pow)
                r_stack[SP_WIDTH'(r_depth - DEPTH_WIDTH'(2))] <= w_alu;
        end else if (r_state == S_DIVIDE && w_op_done) begin
            r_stack[SP_WIDTH'(r_depth - DEPTH_WIDTH'(2))] <= w_div_result;
        end else if (r_state == S_POWER && w_op_done) begin
            r_stack[SP_WIDTH'(r_depth - DEPTH_WIDTH'(2))] <= r_pow_acc;
        end
    end

    assign bus.ready        = w_ready;
    assign bus.token_rd_en  = w_rd_en;
    assign bus.token_index  = r_index;
    assign bus.result       = r_result;
    assign bus.result_valid = r_result_valid;
    assign bus.error        = r_error;
endmodule
`default_nettype wire

// File: tb/tb_rpn_evaluator.sv
`default_nettype none
// ============================================================================
// Module      : tb_rpn_evaluator
// Description : Directed self-checking bench for rpn_evaluator with a token
//               memory model of configurable read latency.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_rpn_evaluator;
    localparam logic [16:0] c_t_plus = 17'h10000;
    localparam logic [16:0] c_t_sub  = 17'h10001;
    localparam logic [16:0] c_t_mul  = 17'h10002;
    localparam logic [16:0] c_t_div  = 17'h10003;
    localparam logic [16:0] c_t_pow  = 17'h10004;
    localparam logic [16:0] c_t_lb   = 17'h10005;
    localparam logic [16:0] c_t_var  = 17'h10006;

    logic        clk = 1'b0;
    logic        rst;
    logic [16:0] mem [64];
    int          checks = 0;
    int          errors = 0;
    int          rd_count = 0;
    int          lat = 1;
    int          pulses;
    logic        got;
    logic [5:0]  rd_idx;

    always #5 clk = ~clk;

    rpn_evaluator_if #(.NUMBER_WIDTH(16), .INDEX_WIDTH(6)) bus ();

    rpn_evaluator #(
        .INTEGER_PART_WIDTH(8),
        .FRACTIONAL_PART_WIDTH(8),
        .TOKEN_QUEUE_SIZE(64),
        .STACK_SIZE(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Token memory: answers each read strobe after `lat` cycles with a one-cycle valid.
    initial begin
        bus.token_valid = 1'b0;
        bus.token_data  = '0;
        forever begin
            @(negedge clk);
            if (bus.token_rd_en === 1'b1) begin
                rd_idx = bus.token_index;
                rd_count++;
                repeat (lat) @(posedge clk);
                #1;
                bus.token_data  = mem[rd_idx];
                bus.token_valid = 1'b1;
                @(posedge clk);
                #1;
                bus.token_valid = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load3(input logic [16:0] t0, input logic [16:0] t1, input logic [16:0] t2);
        mem[0] = t0;
        mem[1] = t1;
        mem[2] = t2;
    endtask

    task automatic run(input logic [15:0] xv, input int cnt, input int l);
        int n;
        lat = l;
        rd_count = 0;
        pulses = 0;
        got = 1'b0;
        n = 0;
        while (bus.ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        bus.x = xv;
        bus.token_count = 6'(cnt);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        while (!got && n < 3000) begin
            @(negedge clk);
            if (bus.result_valid === 1'b1) begin
                got = 1'b1;
                pulses++;
            end
            n++;
        end
        if (!got) check("result_valid_timeout", 32'(got), 32'd1);
        repeat (4) begin
            @(negedge clk);
            if (bus.result_valid === 1'b1) pulses++;
        end
    endtask

    initial begin
        int n;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.x = '0;
        bus.token_count = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(bus.ready), 32'd1);
        check("rst_rd_en", 32'(bus.token_rd_en), 32'd0);
        check("rst_index", 32'(bus.token_index), 32'd0);
        check("rst_result", 32'(bus.result), 32'd0);
        check("rst_valid", 32'(bus.result_valid), 32'd0);
        check("rst_error", 32'(bus.error), 32'd0);

        load3(17'h00200, 17'h00300, c_t_plus);
        run(16'h0000, 3, 1);
        check("add_result", 32'(bus.result), 32'h0500);
        check("add_error", 32'(bus.error), 32'd0);
        check("add_pulses", 32'(pulses), 32'd1);
        check("add_reads", 32'(rd_count), 32'd3);

        run(16'h0000, 3, 5);
        check("add_lat5_result", 32'(bus.result), 32'h0500);
        check("add_lat5_error", 32'(bus.error), 32'd0);

        load3(17'h00200, 17'h00300, c_t_sub);
        run(16'h0000, 3, 1);
        check("sub_result", 32'(bus.result), 32'hFF00);

        load3(c_t_var, c_t_var, c_t_mul);
        run(16'h0180, 3, 2);
        check("var_mul_result", 32'(bus.result), 32'h0240);
        run(16'hFF00, 3, 1);
        check("var_mul_neg_result", 32'(bus.result), 32'h0100);

        load3(17'h0FE00, 17'h00180, c_t_mul);
        run(16'h0000, 3, 1);
        check("mul_signed_result", 32'(bus.result), 32'hFD00);

        load3(17'h00700, 17'h00200, c_t_div);
        run(16'h0000, 3, 1);
        check("div_result", 32'(bus.result), 32'h0380);
        check("div_error", 32'(bus.error), 32'd0);

        load3(17'h0F900, 17'h00200, c_t_div);
        run(16'h0000, 3, 3);
        check("div_neg_result", 32'(bus.result), 32'hFC80);

        load3(17'h00100, 17'h00000, c_t_div);
        mem[3] = 17'h00500;
        run(16'h0000, 4, 1);
        check("div0_error", 32'(bus.error), 32'd1);
        check("div0_reads", 32'(rd_count), 32'd3);
        check("div0_result", 32'(bus.result), 32'd0);
        check("div0_pulses", 32'(pulses), 32'd1);

        load3(17'h00200, 17'h00300, c_t_pow);
        run(16'h0000, 3, 1);
        check("pow_result", 32'(bus.result), 32'h0800);
        load3(17'h00200, 17'h00000, c_t_pow);
        run(16'h0000, 3, 1);
        check("pow0_result", 32'(bus.result), 32'h0100);
        check("pow0_error", 32'(bus.error), 32'd0);
        load3(17'h00200, 17'h0FF00, c_t_pow);
        run(16'h0000, 3, 1);
        check("pow_neg_error", 32'(bus.error), 32'd1);

        mem[0] = c_t_plus;
        run(16'h0000, 1, 1);
        check("underflow_error", 32'(bus.error), 32'd1);

        load3(17'h00200, 17'h00300, c_t_plus);
        run(16'h0000, 2, 1);
        check("leftover_error", 32'(bus.error), 32'd1);
        check("leftover_reads", 32'(rd_count), 32'd2);

        mem[0] = c_t_lb;
        run(16'h0000, 1, 1);
        check("bracket_error", 32'(bus.error), 32'd1);

        run(16'h0000, 0, 1);
        check("empty_error", 32'(bus.error), 32'd1);
        check("empty_reads", 32'(rd_count), 32'd0);

        for (int i = 0; i < 17; i++) mem[i] = 17'h00100;
        run(16'h0000, 17, 1);
        check("overflow_error", 32'(bus.error), 32'd1);
        check("overflow_reads", 32'(rd_count), 32'd17);

        // Reset while the divider is iterating.
        load3(17'h00700, 17'h00200, c_t_div);
        lat = 1;
        rd_count = 0;
        bus.token_count = 6'd3;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        while (rd_count < 3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("rst_div_reads", 32'(rd_count), 32'd3);
        repeat (6) @(negedge clk);
        check("rst_div_busy", 32'(bus.ready), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_div_ready", 32'(bus.ready), 32'd1);
        check("rst_div_rd_en", 32'(bus.token_rd_en), 32'd0);
        check("rst_div_index", 32'(bus.token_index), 32'd0);
        check("rst_div_result", 32'(bus.result), 32'd0);
        check("rst_div_valid", 32'(bus.result_valid), 32'd0);
        check("rst_div_error", 32'(bus.error), 32'd0);

        load3(17'h00200, 17'h00300, c_t_plus);
        run(16'h0000, 3, 1);
        check("post_rst_result", 32'(bus.result), 32'h0500);
        check("post_rst_error", 32'(bus.error), 32'd0);
        check("post_rst_pulses", 32'(pulses), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/rpn_evaluator.md
RPN_EVALUATOR -- requirements
Module: rpn_evaluator

Interface
REQ-001 Parameter INTEGER_PART_WIDTH, default 8: integer bits of the fixed-point number.
REQ-002 Parameter FRACTIONAL_PART_WIDTH, default 8: fraction bits; NUMBER_WIDTH = sum (16); token width = NUMBER_WIDTH+1.
REQ-003 Parameter TOKEN_QUEUE_SIZE, default 64: token memory depth; index width = clog2(TOKEN_QUEUE_SIZE).
REQ-004 Parameter STACK_SIZE, default 16: value-stack depth.
REQ-005 The block SHALL use one clock; reset is synchronous and active-high.
REQ-006 Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  begin an evaluation; sampled only in IDLE.
- ready  out  1  high exactly in IDLE.
- x  in  16  signed Q8.8 variable value; latched on start.
- token_count  in  clog2(TOKEN_QUEUE_SIZE)  number of tokens; latched on start.
- token_rd_en  out  1  one-cycle read strobe.
- token_index  out  clog2(TOKEN_QUEUE_SIZE)  address; held stable until token_valid.
- token_data  in  17  token; bit16=1 operator (bits2:0 opcode), bit16=0 signed Q8.8 operand.
- token_valid  in  1  token_data valid; any latency >=1 cycle after token_rd_en.
- result  out  16  signed Q8.8 result; held until next start.
- result_valid  out  1  one-cycle pulse at evaluation end, success or error.
- error  out  1  set at the end of a failed evaluation; held until next start.

Function
REQ-007 Opcodes: 0 PLUS, 1 SUB, 2 MUL, 3 DIV, 4 POW, 6 VAR; 5 (left bracket) and 7 SHALL raise error.
REQ-008 States: IDLE, FETCH, WAIT_TOKEN, EXEC, DIVIDE, POWER, DONE.
REQ-009 IDLE + start: latch x and token_count, clear index, stack depth, result, error -> FETCH; with token_count=0 -> DONE with error.
REQ-010 FETCH: token_rd_en=1 for one cycle -> WAIT_TOKEN; WAIT_TOKEN waits for token_valid, registers token_data -> EXEC.
REQ-011 EXEC operand: push value. VAR: push latched x. Push with depth=STACK_SIZE -> error.
REQ-012 EXEC binary op: requires depth>=2, else error; b=top, a=top-1; result replaces a, depth decrements.
REQ-013 PLUS/SUB: 16-bit two's-complement a+b / a-b, wrap on overflow.
REQ-014 MUL: 32-bit signed product, arithmetic shift right 8, keep low 16 bits; single cycle.
REQ-015 DIV: b=0 -> error; else restoring divide of |a|<<8 (24 bits) by |b|, one quotient bit per cycle (24 cycles in DIVIDE), negate if signs differ, keep low 16 bits.
REQ-016 POW: exponent n = integer part of b; n<0 -> error; result starts 0x0100 and is multiplied by a (REQ-014 rule) n times, one per cycle in POWER; n=0 gives 0x0100; fraction of b ignored.
REQ-017 After an op completes: index+1; index=token_count -> DONE, else FETCH.
REQ-018 Any error SHALL go to DONE immediately without reading further tokens.
REQ-019 DONE: without error, depth must equal 1 (else error); result=top; pulse result_valid one cycle -> IDLE.
REQ-020 start outside IDLE SHALL be ignored; token_valid outside WAIT_TOKEN SHALL be ignored.

Reset
REQ-021 rst SHALL force IDLE, ready=1, token_rd_en=0, token_index=0, result=0, result_valid=0, error=0, depth=0, in any state including mid-DIVIDE/POWER.
REQ-022 After rst a read already in flight SHALL be discarded; the next start behaves normally.

Verification
REQ-023 Tokens 0x00200,0x00300,0x10000 (2 3 +), count 3 -> result 0x0500, error 0, one result_valid pulse.
REQ-024 x=0x0180, tokens VAR,VAR,MUL -> result 0x0240 (2.25); x=0xFF00 with VAR,VAR,MUL -> 0x0100.
REQ-025 Tokens 0x00700,0x00200,DIV -> 0x0380; 0x00100,0x00000,DIV -> error 1 after token 3, no further reads.
REQ-026 Tokens 0x00200,0x00300,POW -> 0x0800; exponent 0x0000 -> 0x0100; exponent 0xFF00 -> error.
REQ-027 Underflow: single PLUS -> error; two operands, no operator -> error at DONE; 17 pushes -> error; token_valid latency 1 and 5 cycles give identical results.
REQ-028 rst asserted during DIVIDE -> next cycle ready=1, all outputs 0; fresh start of REQ-023 -> 0x0500.
